// File: rtl/sdram_burst_master.sv
// Burst sequencer upstream of the SDRAM controller: buffers write data, holds WR off until the
// whole burst is resident, and turns delayed OUT_VALID/DATAOUT into a one-cycle rd_valid stream.
module sdram_burst_master #(
  parameter int ASIZE   = 23,
  parameter int DSIZE   = 16,
  parameter int FIFO_AW = 8,
  parameter int RD_DLY  = 1
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ASIZE-1:0]   req_addr,
  input  logic [7:0]         req_len,
  input  logic [DSIZE-1:0]   wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic [DSIZE-1:0]   rd_data,
  output logic               rd_valid,
  output logic               cmd_done,
  output logic               err_underflow,
  output logic [ASIZE-1:0]   ADDR,
  output logic [7:0]         LENGTH,
  output logic               WR,
  output logic               RD,
  output logic [DSIZE-1:0]   DATAIN,
  output logic [DSIZE/8-1:0] DM,
  input  logic               IN_REQ,
  input  logic               OUT_VALID,
  input  logic [DSIZE-1:0]   DATAOUT,
  input  logic               DONE
);

  typedef enum logic [2:0] {IDLE, WFILL, ISSUE, XFER, RELEASE} state_t;

  localparam int DEPTH = 1 << FIFO_AW;

  state_t             state, state_nxt;
  logic [DSIZE-1:0]   mem [DEPTH];
  logic [FIFO_AW:0]   wptr, rptr, count;
  logic [DSIZE-1:0]   fifo_head;
  logic               full, empty, push, pop;
  logic [1:0]         done_sync;
  logic               done_s;
  logic [RD_DLY-1:0]  ov_pipe;
  logic               ov_d;
  logic               dir_q;
  logic [7:0]         beat;
  logic               accept, wr_beat, rd_beat, underflow;

  // Pointers carry one extra wrap bit, so the difference is the true occupancy 0..DEPTH.
  assign count     = wptr - rptr;
  assign full      = count[FIFO_AW];
  assign empty     = (count == '0);
  assign fifo_head = mem[rptr[FIFO_AW-1:0]];
  assign wr_ready  = !full;
  assign push      = wr_valid && !full;

  assign done_s    = done_sync[1];
  assign ov_d      = ov_pipe[RD_DLY-1];
  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign DM        = '0;

  assign wr_beat   = IN_REQ && (state == XFER) && dir_q && (beat != 8'd0);
  assign pop       = wr_beat && !empty;
  assign rd_beat   = ov_d && (state == XFER) && !dir_q && (beat != 8'd0);
  // Trailing IN_REQ after the last beat of a write is tolerated; any other request on an empty FIFO is flagged.
  assign underflow = IN_REQ && empty && !((state == XFER) && dir_q && (beat == 8'd0));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (req_len != 8'd0)) state_nxt = req_write ? WFILL : ISSUE;
      WFILL:   if (count >= {1'b0, LENGTH}) state_nxt = ISSUE;
      ISSUE:   state_nxt = XFER;
      XFER:    if (done_s && (beat == 8'd0)) state_nxt = RELEASE;
      RELEASE: if (!done_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wptr[FIFO_AW-1:0]] <= wr_data;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      wptr          <= '0;
      rptr          <= '0;
      done_sync     <= '0;
      ov_pipe       <= '0;
      ADDR          <= '0;
      LENGTH        <= '0;
      dir_q         <= 1'b0;
      beat          <= '0;
      WR            <= 1'b0;
      RD            <= 1'b0;
      DATAIN        <= '0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      cmd_done      <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state      <= state_nxt;
      done_sync  <= {done_sync[0], DONE};
      ov_pipe[0] <= OUT_VALID;
      for (int i = 1; i < RD_DLY; i++) ov_pipe[i] <= ov_pipe[i-1];

      if (push) wptr <= wptr + (FIFO_AW+1)'(1);
      if (pop)  rptr <= rptr + (FIFO_AW+1)'(1);

      if (accept) begin
        ADDR   <= req_addr;
        LENGTH <= req_len;
        dir_q  <= req_write;
        beat   <= req_len;
      end else if (wr_beat || rd_beat) begin
        beat   <= beat - 8'd1;
      end

      // Request levels are high exactly while the FSM sits in XFER.
      WR <= (state_nxt == XFER) && dir_q;
      RD <= (state_nxt == XFER) && !dir_q;

      if (wr_beat) DATAIN <= empty ? '0 : fifo_head;
      rd_valid <= rd_beat;
      if (rd_beat) rd_data <= DATAOUT;

      cmd_done <= (accept && (req_len == 8'd0)) || ((state == RELEASE) && !done_s);
      if (underflow) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_burst_master.sv
// Directed bench for sdram_burst_master with a queue-based behavioural model and per-cycle compare.
module tb_sdram_burst_master;

  logic        CLK;
  logic        RESET_N;
  logic        req_valid, req_ready, req_write;
  logic [22:0] req_addr;
  logic [7:0]  req_len;
  logic [15:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid, cmd_done, err_underflow;
  logic [22:0] ADDR;
  logic [7:0]  LENGTH;
  logic        WR, RD;
  logic [15:0] DATAIN;
  logic [1:0]  DM;
  logic        IN_REQ, OUT_VALID;
  logic [15:0] DATAOUT;
  logic        DONE;

  sdram_burst_master dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .cmd_done(cmd_done),
    .err_underflow(err_underflow),
    .ADDR(ADDR), .LENGTH(LENGTH), .WR(WR), .RD(RD),
    .DATAIN(DATAIN), .DM(DM),
    .IN_REQ(IN_REQ), .OUT_VALID(OUT_VALID), .DATAOUT(DATAOUT), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: FIFO contents, expected read stream, current burst.
  logic [15:0] mq[$];
  logic [15:0] exp_rd[$];
  logic [15:0] exp_datain = '0;
  bit          m_err = 0;
  bit          m_dir = 0;
  logic [22:0] m_addr = '0;
  logic [7:0]  m_len = '0;
  logic [7:0]  m_left = '0;
  bit          m_active = 0;
  bit          m_expect_done = 0;
  bit          prev_ov = 0;
  bit          do_push;

  initial forever begin
    @(posedge CLK);
    if (!RESET_N) begin
      mq.delete();
      exp_rd.delete();
      exp_datain = '0; m_err = 0; m_active = 0; m_expect_done = 0;
      prev_ov = 0; m_left = '0; m_addr = '0; m_len = '0;
    end else begin
      do_push = wr_valid && (mq.size() < 256);
      if (cmd_done) begin m_active = 0; m_expect_done = 0; end
      if (req_valid && req_ready) begin
        m_addr = req_addr; m_len = req_len; m_dir = req_write; m_left = req_len;
        m_expect_done = 1; m_active = (req_len != 8'd0);
      end
      if (IN_REQ) begin
        if (m_active && m_dir && m_left != 0) begin
          if (mq.size() > 0) exp_datain = mq.pop_front();
          else begin exp_datain = '0; m_err = 1; end
          m_left--;
        end else if (!(m_active && m_dir && m_left == 0) && mq.size() == 0) begin
          m_err = 1;
        end
      end
      if (prev_ov && m_active && !m_dir && m_left != 0) begin
        exp_rd.push_back(DATAOUT);
        m_left--;
      end
      prev_ov = OUT_VALID;
      if (do_push) mq.push_back(wr_data);
    end
  end

  bit prev_wr = 0;
  logic [15:0] rd_exp_word;

  initial forever begin
    @(negedge CLK);
    if (RESET_N) begin
      check("wr_ready", wr_ready, mq.size() < 256);
      check("datain", DATAIN, exp_datain);
      check("err_underflow", err_underflow, m_err);
      check("dm", DM, 0);
      check("wr_rd_exclusive", WR && RD, 0);
      if (WR || RD) begin
        check("addr_stable", ADDR, m_addr);
        check("length_stable", LENGTH, m_len);
        check("dir", WR, m_dir);
      end
      if (WR && !prev_wr) check("wr_burst_buffered", mq.size() >= m_len, 1);
      prev_wr = WR;
      if (rd_valid) begin
        if (exp_rd.size() == 0) check("rd_unexpected", rd_valid, 0);
        else begin
          rd_exp_word = exp_rd.pop_front();
          check("rd_data", rd_data, rd_exp_word);
        end
      end
      if (cmd_done) check("cmd_done_expected", cmd_done, m_expect_done);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic bit sig(input int s);
    case (s)
      0: return WR;
      1: return RD;
      2: return cmd_done;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string nm, input int s, input bit lvl, input int budget);
    int cyc = 0;
    while (sig(s) !== lvl && cyc < budget) begin
      tick();
      cyc++;
    end
    check(nm, sig(s), lvl);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    IN_REQ = 0; OUT_VALID = 0; DONE = 0; wr_valid = 0; req_valid = 0;
    repeat (2) tick();
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic push_word(input logic [15:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic send_req(input bit w, input logic [22:0] a, input logic [7:0] l);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
    while (!req_ready && n < 50) begin tick(); n++; end
    check("req_ready_wait", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic write_beats(input int n);
    IN_REQ = 1'b1;
    repeat (n) tick();
    IN_REQ = 1'b0;
  endtask

  // Controller side of completion: raise DONE, wait for the level to drop, lower DONE, expect one pulse.
  task automatic finish_burst(input int s);
    DONE = 1'b1;
    wait_for("level_release", s, 1'b0, 10);
    DONE = 1'b0;
    wait_for("cmd_done_pulse", 2, 1'b1, 10);
    check("req_ready_after_done", req_ready, 1);
    tick();
    check("cmd_done_single", cmd_done, 0);
  endtask

  logic [15:0] wtbl [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] rtbl [4] = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};

  initial begin
    RESET_N = 0; req_valid = 0; req_write = 0; req_addr = '0; req_len = '0;
    wr_data = '0; wr_valid = 0; IN_REQ = 0; OUT_VALID = 0; DATAOUT = '0; DONE = 0;
    repeat (3) tick();
    RESET_N = 1;
    tick();

    check("rst_req_ready", req_ready, 1);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_wr", WR, 0);
    check("rst_rd", RD, 0);
    check("rst_cmd_done", cmd_done, 0);
    check("rst_err", err_underflow, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_datain", DATAIN, 0);

    // Reset in the middle of a write transfer.
    for (int i = 0; i < 8; i++) push_word(16'h0100 + 16'(i));
    send_req(1'b1, 23'h000123, 8'd8);
    wait_for("t1_wr_up", 0, 1'b1, 6);
    write_beats(3);
    check("t1_datain_third", DATAIN, 16'h0102);
    RESET_N = 1'b0;
    #1;
    check("t1_wr_drop_on_reset", WR, 0);
    repeat (2) tick();
    RESET_N = 1'b1;
    tick();
    check("t1_req_ready", req_ready, 1);
    check("t1_wr_ready", wr_ready, 1);
    check("t1_err", err_underflow, 0);

    // Four-word write: WR must wait for the fourth word.
    send_req(1'b1, 23'h000100, 8'd4);
    for (int i = 0; i < 4; i++) begin
      push_word(wtbl[i]);
      check("t2_wr_low_while_filling", WR, 0);
    end
    wait_for("t2_wr_up", 0, 1'b1, 3);
    check("t2_addr", ADDR, 23'h000100);
    check("t2_length", LENGTH, 8'd4);
    IN_REQ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_datain_seq", DATAIN, wtbl[i]);
    end
    IN_REQ = 1'b0;
    finish_burst(0);

    // Sixteen-word write with only ten buffered, then the rest; one extra IN_REQ is ignored.
    for (int i = 0; i < 10; i++) push_word(16'h0500 + 16'(i));
    send_req(1'b1, 23'h002000, 8'd16);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t3_wfill_wr_low", WR, 0);
    end
    for (int i = 10; i < 16; i++) push_word(16'h0500 + 16'(i));
    wait_for("t3_wr_within_2", 0, 1'b1, 2);
    write_beats(17);
    check("t3_datain_last", DATAIN, 16'h050F);
    check("t3_no_err", err_underflow, 0);
    finish_burst(0);

    // Read burst at the top address with a discarded fourth beat.
    send_req(1'b0, 23'h7FFFFF, 8'd3);
    wait_for("t4_rd_up", 1, 1'b1, 4);
    check("t4_addr", ADDR, 23'h7FFFFF);
    for (int k = 0; k < 5; k++) begin
      OUT_VALID = (k < 4);
      DATAOUT   = (k > 0) ? rtbl[k-1] : 16'h0000;
      tick();
      check("t4_rd_valid", rd_valid, (k >= 1 && k <= 3));
      if (k >= 1 && k <= 3) check("t4_rd_data", rd_data, rtbl[k-1]);
    end
    OUT_VALID = 1'b0;
    DATAOUT   = '0;
    check("t4_rd_held", RD, 1);
    finish_burst(1);
    check("t4_rd_all_seen", exp_rd.size(), 0);

    // Fill the FIFO to capacity; a 257th push must be dropped.
    wr_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wr_data = 16'h0C00 + 16'(i);
      tick();
    end
    check("t5_full", wr_ready, 0);
    wr_data = 16'hDEAD;
    tick();
    wr_valid = 1'b0;
    check("t5_still_full", wr_ready, 0);

    // Zero-length request completes on its own with the FIFO full.
    send_req(1'b1, 23'h000040, 8'd0);
    check("t5_len0_done", cmd_done, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_len0_no_wr", WR || RD, 0);
    end
    check("t5_len0_single", cmd_done, 0);

    // Drain 255 + 1 words; the last one must be word 255, not the dropped push.
    send_req(1'b1, 23'h000040, 8'd255);
    wait_for("t5_wr_up", 0, 1'b1, 4);
    write_beats(255);
    finish_burst(0);
    send_req(1'b1, 23'h000041, 8'd1);
    wait_for("t5_wr1_up", 0, 1'b1, 4);
    write_beats(1);
    check("t5_last_word", DATAIN, 16'h0CFF);
    finish_burst(0);

    // Spurious IN_REQ with the FIFO empty: sticky error until reset.
    IN_REQ = 1'b1;
    tick();
    IN_REQ = 1'b0;
    check("t6_err_set", err_underflow, 1);
    repeat (5) tick();
    check("t6_err_sticky", err_underflow, 1);
    do_reset();
    check("t6_err_cleared", err_underflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_burst_master.md
Name: sdram_burst_master

Overview:
- Host-side burst sequencer that sits directly upstream of the SDRAM controller.
- Accepts burst requests (address, length, direction) from a client and buffers write data in an internal FIFO.
- Drives the controller's WR/RD/ADDR/LENGTH level handshake, streams write data on IN_REQ and returns read data as a valid-qualified stream.
- Guarantees the controller never starts a write burst without the full burst already buffered.

Parameters:
- ASIZE, 23, SDRAM word address width.
- DSIZE, 16, data width.
- FIFO_AW, 8, write FIFO address width (depth 2^FIFO_AW = 256 words).
- RD_DLY, 1, CLK cycles from controller OUT_VALID to the corresponding word being present on DATAOUT.

Ports:
- CLK  in  1  system clock (same clock as the controller CLK)
- RESET_N  in  1  asynchronous active-low reset
- req_valid  in  1  burst request valid
- req_ready  out  1  block can accept a request
- req_write  in  1  1=write burst, 0=read burst
- req_addr  in  ASIZE  burst start address
- req_len  in  8  burst length in words
- wr_data  in  DSIZE  write data word
- wr_valid  in  1  write data valid
- wr_ready  out  1  write FIFO not full
- rd_data  out  DSIZE  read data word
- rd_valid  out  1  read data valid (single-cycle, no backpressure)
- cmd_done  out  1  one-cycle pulse when a burst completes
- err_underflow  out  1  sticky: IN_REQ seen with write FIFO empty
- ADDR  out  ASIZE  to controller
- LENGTH  out  8  to controller
- WR  out  1  to controller, write request level
- RD  out  1  to controller, read request level
- DATAIN  out  DSIZE  to controller, write data
- DM  out  DSIZE/8  to controller, always 0
- IN_REQ  in  1  from controller, write data request
- OUT_VALID  in  1  from controller, read data valid
- DATAOUT  in  DSIZE  from controller, read data
- DONE  in  1  from controller, asynchronous to CLK

Behaviour:
- Reset values: all outputs 0 except req_ready=1 and wr_ready=1. FIFO is emptied and err_underflow is cleared. Reset mid-burst drops WR/RD immediately and abandons the burst.
- DONE passes through a 2-flop synchroniser to give done_s. All DONE decisions use done_s.
- Write FIFO: push when wr_valid && wr_ready. wr_ready = !full. Pointers are FIFO_AW+1 bits and wrap modulo 2^(FIFO_AW+1). Simultaneous push and pop is allowed and leaves the count unchanged.
- Request acceptance: a request is taken when req_valid && req_ready. req_ready is 1 only in IDLE.
- On acceptance, latch ADDR, LENGTH, dir and beat counter := req_len.
- req_len==0: accept, no SDRAM access, cmd_done pulses on the next cycle, stay IDLE.
- States:
  - IDLE -> (write) WFILL | (read) ISSUE.
  - WFILL: wait until FIFO count >= LENGTH, then go to ISSUE.
  - ISSUE: assert WR (write) or RD (read) on the next edge, then go to XFER.
  - XFER: hold WR/RD. Leave when done_s==1 AND beat counter==0 (both conditions), then go to RELEASE.
  - RELEASE: WR=RD=0. Wait until done_s==0, then pulse cmd_done for one cycle and go to IDLE.
- Write beats: on each CLK with IN_REQ==1 in XFER, DATAIN <= FIFO head (registered), pop, and decrement the beat counter. If the FIFO is empty, DATAIN <= 0, no pop, set err_underflow. IN_REQ beyond LENGTH beats is ignored with no pop.
- Read beats: delay OUT_VALID by RD_DLY cycles to give ov_d. On ov_d, rd_data <= DATAOUT, rd_valid=1 for one cycle, and decrement the beat counter. Extra beats beyond LENGTH are discarded.
- ADDR/LENGTH remain stable from ISSUE until RELEASE exits.
- DM is tied to 0.

Test Plan:
- Reset mid-XFER (write, len 8, after 3 IN_REQ) -> WR=0 same cycle as reset assertion; after release: req_ready=1, FIFO empty, err_underflow=0.
- Push 4 words 0x1111..0x4444, request write addr 0x000100 len 4:
  - WR rises only after the 4th word is buffered.
  - DATAIN presents 0x1111,0x2222,0x3333,0x4444 on successive IN_REQ cycles.
  - After DONE high then low, exactly one cmd_done pulse, then req_ready=1.
- Request write len 16 with only 10 words pushed -> stays in WFILL, WR=0. Pushing 6 more -> WR asserts within 2 cycles.
- Read addr 0x7FFFFF len 3, model drives OUT_VALID 3 cycles with DATAOUT 0xA0,0xA1,0xA2 -> exactly 3 rd_valid pulses with those values in order. RD stays high until DONE; an extra 4th OUT_VALID beat is discarded.
- Fill FIFO with 256 words -> wr_ready=0 and a 257th push is ignored. A request with req_len=0 -> cmd_done one cycle later, WR/RD never asserted.
- Force IN_REQ with FIFO empty (model misbehaviour) -> err_underflow=1 and sticky until reset.
